// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester port bundle for the shared-memory arbiter
interface mem_arbiter_if #(
  parameter int AW = 6,
  parameter int DW = 9
);
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          gnt;
  logic          done;
  logic [DW-1:0] rdata;

  modport master (output req, we, addr, wdata, input gnt, done, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, done, rdata);
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port round-robin arbiter for the shared 64x9 memory
module mem_arbiter #(
  parameter int AW          = 6,
  parameter int DW          = 9,
  parameter int HOLD_CYCLES = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.slave  p0,
  mem_arbiter_if.slave  p1,
  output logic          READ,
  output logic          WRITE,
  output logic [AW-1:0] A,
  output logic [DW-1:0] DATA,
  input  logic [DW-1:0] D
);
  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, ACC, RESP} state_t;

  state_t        state, state_d;
  logic          last, w_q, we_q;
  logic [AW-1:0] a_q;
  logic [DW-1:0] d_q;
  logic [CW-1:0] cnt;
  logic          gnt0_q, gnt1_q, done0_q, done1_q;
  logic [DW-1:0] rdata0_q, rdata1_q;
  logic          win, start, finish;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // Strobes decode from state so an async reset drops them immediately.
  always_comb begin
    state_d = state;
    win     = last;
    start   = 1'b0;
    finish  = 1'b0;
    READ    = 1'b0;
    WRITE   = 1'b0;
    case (state)
      IDLE: begin
        if (p0.req || p1.req) begin
          start   = 1'b1;
          win     = p1.req & (~p0.req | ~last);
          state_d = ACC;
        end
      end
      ACC: begin
        READ  = ~we_q;
        WRITE = we_q;
        if (cnt == '0) begin
          finish  = 1'b1;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last     <= 1'b1;
      w_q      <= 1'b0;
      we_q     <= 1'b0;
      a_q      <= '0;
      d_q      <= '0;
      cnt      <= '0;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      gnt0_q  <= start & ~win;
      gnt1_q  <= start & win;
      done0_q <= finish & ~w_q;
      done1_q <= finish & w_q;
      if (start) begin
        w_q  <= win;
        last <= win;
        we_q <= win ? p1.we : p0.we;
        a_q  <= win ? p1.addr : p0.addr;
        d_q  <= win ? p1.wdata : p0.wdata;
        cnt  <= CW'(HOLD_CYCLES - 1);
      end else if (state == ACC && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      // Only the owning port's read data moves; writes leave both untouched.
      if (finish && !we_q) begin
        if (w_q) rdata1_q <= D;
        else     rdata0_q <= D;
      end
    end
  end

  assign A        = a_q;
  assign DATA     = d_q;
  assign p0.gnt   = gnt0_q;
  assign p1.gnt   = gnt1_q;
  assign p0.done  = done0_q;
  assign p1.done  = done1_q;
  assign p0.rdata = rdata0_q;
  assign p1.rdata = rdata1_q;
endmodule
